// File: rtl/axi_bus_arbiter_pkg.sv
// Shared types and constants for the AXI3 bus arbiter.
// The read-FSM encodings, channel widths and default IDs live here.
package axi_bus_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

  localparam logic [ID_W-1:0]    ID_I_DEF   = 4'd0;
  localparam logic [ID_W-1:0]    ID_D_DEF   = 4'd1;
  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } port_sel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_req_t;

endpackage

// File: rtl/axi_bus_arbiter_pick2.sv
// Combinational two-way picker: req[1] = dcache, req[0] = icache.
// With rr_en low the dcache always wins a tie; with rr_en high the port not served last wins.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && last) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI3 master port between the icache (read bursts) and the dcache (reads, writes).
// Define AXI_ARB_RR_EN for round-robin read arbitration; the default is fixed dcache-first priority.
module axi_bus_arbiter
  import axi_bus_arbiter_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_I = ID_I_DEF,
  parameter logic [ID_W-1:0] ID_D = ID_D_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,

  input  logic [ADDR_W-1:0]  i_araddr,
  input  logic [LEN_W-1:0]   i_arlen,
  input  logic [SIZE_W-1:0]  i_arsize,
  input  logic               i_arvalid,
  output logic               i_arready,
  output logic [DATA_W-1:0]  i_rdata,
  output logic               i_rlast,
  output logic               i_rvalid,

  input  logic [ADDR_W-1:0]  d_araddr,
  input  logic [LEN_W-1:0]   d_arlen,
  input  logic [SIZE_W-1:0]  d_arsize,
  input  logic               d_arvalid,
  output logic               d_arready,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_rlast,
  output logic               d_rvalid,

  input  logic [ADDR_W-1:0]  d_awaddr,
  input  logic [LEN_W-1:0]   d_awlen,
  input  logic [SIZE_W-1:0]  d_awsize,
  input  logic               d_awvalid,
  output logic               d_awready,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic [STRB_W-1:0]  d_wstrb,
  input  logic               d_wlast,
  input  logic               d_wvalid,
  output logic               d_wready,
  output logic [RESP_W-1:0]  d_bresp,
  output logic               d_bvalid,

  output logic [ID_W-1:0]    m_arid,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic [LEN_W-1:0]   m_arlen,
  output logic [SIZE_W-1:0]  m_arsize,
  output logic [BURST_W-1:0] m_arburst,
  output logic [LOCK_W-1:0]  m_arlock,
  output logic [CACHE_W-1:0] m_arcache,
  output logic [PROT_W-1:0]  m_arprot,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready,

  output logic [ID_W-1:0]    m_awid,
  output logic [ADDR_W-1:0]  m_awaddr,
  output logic [LEN_W-1:0]   m_awlen,
  output logic [SIZE_W-1:0]  m_awsize,
  output logic [BURST_W-1:0] m_awburst,
  output logic [LOCK_W-1:0]  m_awlock,
  output logic [CACHE_W-1:0] m_awcache,
  output logic [PROT_W-1:0]  m_awprot,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [ID_W-1:0]    m_wid,
  output logic [DATA_W-1:0]  m_wdata,
  output logic [STRB_W-1:0]  m_wstrb,
  output logic               m_wlast,
  output logic               m_wvalid,
  input  logic               m_wready,
  input  logic [RESP_W-1:0]  m_bresp,
  input  logic               m_bvalid,
  output logic               m_bready
);

  rd_state_t state;
  port_sel_t grant;
  ar_req_t   ar_q;
  ar_req_t   i_req;
  ar_req_t   d_req;
  logic      arvalid_q;
  logic      rready_q;
  logic      wr_outstanding;
  logic [1:0] req;
  logic [1:0] gnt;
  logic      last_sel;
  logic      rr_en;

  assign i_req = '{addr: i_araddr, len: i_arlen, size: i_arsize};
  assign d_req = '{addr: d_araddr, len: d_arlen, size: d_arsize};

  // A dcache read may not overtake its own write: hold it while a write is pending or in flight.
  assign req = {d_arvalid & ~wr_outstanding & ~d_awvalid, i_arvalid};

`ifdef AXI_ARB_RR_EN
  port_sel_t last_grant;

  assign rr_en    = 1'b1;
  assign last_sel = (last_grant == SEL_D);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant <= SEL_I;
    end else if (state == R_IDLE && |gnt) begin
      last_grant <= gnt[1] ? SEL_D : SEL_I;
    end
  end
`else
  assign rr_en    = 1'b0;
  assign last_sel = 1'b0;
`endif

  arb_pick2 u_pick (
    .req   (req),
    .last  (last_sel),
    .rr_en (rr_en),
    .gnt   (gnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  // NOTE: the latched request payload is reset along with the control flops; it is a few bits, not a memory array.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= R_IDLE;
      grant     <= SEL_I;
      ar_q      <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (|gnt) begin
            grant     <= gnt[1] ? SEL_D : SEL_I;
            ar_q      <= gnt[1] ? d_req : i_req;
            arvalid_q <= 1'b1;
            state     <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_rvalid && m_rlast) begin
            rready_q <= 1'b0;
            state    <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state     <= R_IDLE;
        end
      endcase
    end
  end

  // Set wins over clear, so a new AW accepted in the same cycle as a B keeps the flag up.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_outstanding <= 1'b0;
    end else if (m_awvalid && m_awready) begin
      wr_outstanding <= 1'b1;
    end else if (m_bvalid && m_bready) begin
      wr_outstanding <= 1'b0;
    end
  end

  assign m_arid    = (grant == SEL_D) ? ID_D : ID_I;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = BURST_INCR;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  assign i_arready = arvalid_q & m_arready & (grant == SEL_I);
  assign d_arready = arvalid_q & m_arready & (grant == SEL_D);

  // Only one read is ever outstanding, so the beat belongs to the granted port without looking at RID.
  assign i_rvalid  = rready_q & m_rvalid & (grant == SEL_I);
  assign d_rvalid  = rready_q & m_rvalid & (grant == SEL_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign i_rlast   = i_rvalid & m_rlast;
  assign d_rlast   = d_rvalid & m_rlast;

  assign m_awid    = ID_D;
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awburst = BURST_INCR;
  assign m_awlock  = '0;
  assign m_awcache = '0;
  assign m_awprot  = '0;
  assign m_awvalid = d_awvalid;
  assign d_awready = m_awready;

  assign m_wid     = ID_D;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = d_wvalid;
  assign d_wready  = m_wready;

  assign d_bresp   = m_bresp;
  assign d_bvalid  = m_bvalid;
  assign m_bready  = 1'b1;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: table of read scenarios plus hand sequences for
// reset, tie ordering, read-after-write hold and icache-during-write.
module tb_axi_bus_arbiter;
  import axi_bus_arbiter_pkg::*;

  localparam logic [3:0] TID_I = 4'd0;
  localparam logic [3:0] TID_D = 4'd1;

`ifdef AXI_ARB_RR_EN
  localparam logic [3:0] TIE_FIRST = TID_I;
  localparam logic [3:0] SEQ1      = TID_I;
`else
  localparam logic [3:0] TIE_FIRST = TID_D;
  localparam logic [3:0] SEQ1      = TID_D;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] i_araddr, d_araddr, d_awaddr;
  logic [3:0]  i_arlen, d_arlen, d_awlen;
  logic [2:0]  i_arsize, d_arsize, d_awsize;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid;
  logic [31:0] i_rdata, d_rdata, d_wdata;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid;
  logic [3:0]  d_wstrb;
  logic [1:0]  d_bresp;
  logic [3:0]  m_arid, m_arlen, m_arcache, m_awid, m_awlen, m_awcache, m_wid, m_wstrb;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_arlock, m_awburst, m_awlock, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  always #5 aclk = ~aclk;

  axi_bus_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bresp(d_bresp), .d_bvalid(d_bvalid),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_rec_t;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [3:0]  i_len;
    logic [3:0]  d_len;
    logic [3:0]  exp_id0;
    int          exp_i_beats;
    int          exp_d_beats;
    int          exp_ars;
  } vec_t;

  ar_rec_t ar_log[$];
  int      b_delay = 5;
  int      n_checks = 0;
  int      n_fail = 0;
  int      i_beats, d_beats, i_lasts, d_lasts, both_cnt;
  logic [31:0] i_exp, d_exp;
  bit      hold_ar = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    ar_log.delete();
    i_beats = 0; d_beats = 0; i_lasts = 0; d_lasts = 0; both_cnt = 0;
  endtask

  // One cycle of cache-side behaviour: sample at negedge, then drop arvalid after an AR handshake.
  task automatic tick();
    logic i_hs, d_hs;
    @(negedge aclk);
    i_hs = i_arvalid & i_arready;
    d_hs = d_arvalid & d_arready;
    if (i_rvalid) begin
      i_beats++;
      check("i_rdata", i_rdata, i_exp);
      if (i_rlast) begin i_lasts++; i_exp = i_araddr; end
      else i_exp = i_exp + 32'd4;
    end
    if (d_rvalid) begin
      d_beats++;
      check("d_rdata", d_rdata, d_exp);
      if (d_rlast) begin d_lasts++; d_exp = d_araddr; end
      else d_exp = d_exp + 32'd4;
    end
    if (i_rvalid && d_rvalid) both_cnt++;
    @(posedge aclk); #1;
    if (i_hs && !hold_ar) i_arvalid = 1'b0;
    if (d_hs && !hold_ar) d_arvalid = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
    d_awaddr = addr; d_awlen = 4'd0; d_awsize = 3'd2; d_awvalid = 1'b1;
    d_wdata = data; d_wstrb = 4'hF; d_wlast = 1'b1; d_wvalid = 1'b1;
  endtask

  // Simple AXI slave: accepts one AR at a time, returns len+1 beats of addr+4*k, B after b_delay cycles.
  initial begin : slave
    logic s_arv, s_ar_hs, s_r_hs, s_aw_hs, s_b_hs;
    logic [3:0]  s_arid, s_arlen, rd_len;
    logic [31:0] s_araddr, rd_addr;
    int rd_beat, b_cnt;
    bit rd_busy;
    rd_busy = 1'b0; b_cnt = 0; rd_beat = 0; rd_len = 4'd0; rd_addr = 32'd0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = 32'd0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(negedge aclk);
      s_arv    = m_arvalid;
      s_ar_hs  = m_arvalid & m_arready;
      s_r_hs   = m_rvalid & m_rready;
      s_aw_hs  = m_awvalid & m_awready;
      s_b_hs   = m_bvalid & m_bready;
      s_arid   = m_arid;
      s_araddr = m_araddr;
      s_arlen  = m_arlen;
      @(posedge aclk); #2;
      if (!aresetn) begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
        rd_busy = 1'b0; b_cnt = 0;
      end else begin
        if (s_ar_hs) begin
          ar_log.push_back('{s_arid, s_araddr, s_arlen});
          rd_addr = s_araddr; rd_len = s_arlen; rd_beat = 0; rd_busy = 1'b1;
          m_rvalid = 1'b1; m_rdata = s_araddr; m_rlast = (s_arlen == 4'd0);
        end else if (s_r_hs) begin
          if (m_rlast) begin
            m_rvalid = 1'b0; m_rlast = 1'b0; rd_busy = 1'b0;
          end else begin
            rd_beat++;
            m_rdata = rd_addr + 32'(rd_beat) * 32'd4;
            m_rlast = (rd_beat == int'(rd_len));
          end
        end
        m_arready = s_arv && !s_ar_hs && !rd_busy;
        if (s_b_hs) m_bvalid = 1'b0;
        if (s_aw_hs) b_cnt = b_delay;
        else if (b_cnt > 0) begin
          b_cnt--;
          if (b_cnt == 0) m_bvalid = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[4];
    bit   seen_b, found;

    vecs[0] = '{1'b1, 1'b0, 32'h1FC0_0000, 32'h0, 4'h7, 4'h0, TID_I, 8, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_0040, 4'h0, 4'h0, TID_D, 0, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 32'h1FC0_0100, 32'h8000_0080, 4'h3, 4'h0, TIE_FIRST, 4, 1, 2};
    vecs[3] = '{1'b1, 1'b1, 32'h1FC0_0200, 32'h8000_00C0, 4'h1, 4'h0, TIE_FIRST, 2, 1, 2};

    aresetn = 1'b0;
    i_araddr = 32'h0000_0100; i_arlen = 4'd1; i_arsize = 3'd2; i_arvalid = 1'b1;
    d_araddr = 32'h0000_0200; d_arlen = 4'd1; d_arsize = 3'd2; d_arvalid = 1'b1;
    d_awaddr = 32'd0; d_awlen = 4'd0; d_awsize = 3'd0; d_awvalid = 1'b0;
    d_wdata = 32'd0; d_wstrb = 4'd0; d_wlast = 1'b0; d_wvalid = 1'b0;
    i_exp = i_araddr; d_exp = d_araddr;
    clear_counts();

    // Reset state with both requesters already asserting arvalid.
    repeat (2) @(negedge aclk);
    check("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_m_rready",  32'(m_rready),  32'd0);
    check("rst_i_arready", 32'(i_arready), 32'd0);
    check("rst_d_arready", 32'(d_arready), 32'd0);
    check("rst_i_rvalid",  32'(i_rvalid),  32'd0);
    check("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    check("rst_m_bready",  32'(m_bready),  32'd1);
    check("fixed_arburst", 32'(m_arburst), 32'd1);
    check("fixed_arlock",  32'({m_arlock, m_arcache, m_arprot}), 32'd0);
    check("fixed_awburst", 32'(m_awburst), 32'd1);
    check("fixed_awlock",  32'({m_awlock, m_awcache, m_awprot}), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Three consecutive ties with both requesters holding arvalid.
    hold_ar = 1'b1;
    for (int c = 0; c < 300 && ar_log.size() < 3; c++) tick();
    hold_ar = 1'b0;
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    repeat (8) tick();
    check("tie_seq_count", 32'(ar_log.size()), 32'd3);
    if (ar_log.size() >= 3) begin
      check("tie_seq_0", 32'(ar_log[0].id), 32'(TID_D));
      check("tie_seq_1", 32'(ar_log[1].id), 32'(SEQ1));
      check("tie_seq_2", 32'(ar_log[2].id), 32'(TID_D));
    end
    check("tie_seq_overlap", 32'(both_cnt), 32'd0);

    // Table-driven read scenarios.
    for (int k = 0; k < 4; k++) begin
      clear_counts();
      i_araddr = vecs[k].i_addr; i_arlen = vecs[k].i_len; i_exp = vecs[k].i_addr;
      d_araddr = vecs[k].d_addr; d_arlen = vecs[k].d_len; d_exp = vecs[k].d_addr;
      i_arvalid = vecs[k].i_req; d_arvalid = vecs[k].d_req;
      for (int c = 0; c < 200 && !(i_lasts == int'(vecs[k].i_req) && d_lasts == int'(vecs[k].d_req)); c++)
        tick();
      repeat (2) tick();
      check($sformatf("v%0d_ar_count", k), 32'(ar_log.size()), 32'(vecs[k].exp_ars));
      if (ar_log.size() > 0) begin
        check($sformatf("v%0d_first_id", k), 32'(ar_log[0].id), 32'(vecs[k].exp_id0));
        check($sformatf("v%0d_first_addr", k), ar_log[0].addr,
              (vecs[k].exp_id0 == TID_I) ? vecs[k].i_addr : vecs[k].d_addr);
      end
      check($sformatf("v%0d_i_beats", k), 32'(i_beats), 32'(vecs[k].exp_i_beats));
      check($sformatf("v%0d_d_beats", k), 32'(d_beats), 32'(vecs[k].exp_d_beats));
      check($sformatf("v%0d_i_rlast", k), 32'(i_lasts), 32'(vecs[k].i_req));
      check($sformatf("v%0d_overlap", k), 32'(both_cnt), 32'd0);
    end

    // Icache drops arvalid while the bus is busy: no icache request may be issued.
    clear_counts();
    d_araddr = 32'h8000_0100; d_arlen = 4'd7; d_exp = d_araddr; d_arvalid = 1'b1;
    for (int c = 0; c < 50 && ar_log.size() < 1; c++) tick();
    i_araddr = 32'h1FC0_0300; i_arlen = 4'd0; i_exp = i_araddr; i_arvalid = 1'b1;
    repeat (2) tick();
    i_arvalid = 1'b0;
    for (int c = 0; c < 50 && d_lasts < 1; c++) tick();
    repeat (3) tick();
    check("drop_ar_count", 32'(ar_log.size()), 32'd1);
    check("drop_i_beats", 32'(i_beats), 32'd0);
    check("drop_d_beats", 32'(d_beats), 32'd8);

    // Read-after-write: the dcache read waits for the B handshake.
    clear_counts();
    b_delay = 5;
    drive_write(32'h8000_1000, 32'hCAFE_F00D);
    d_araddr = 32'h8000_1000; d_arlen = 4'd0; d_exp = d_araddr; d_arvalid = 1'b1;
    #1;
    check("wr_awaddr", m_awaddr, 32'h8000_1000);
    check("wr_awvalid", 32'(m_awvalid), 32'd1);
    check("wr_ids", 32'({m_awid, m_wid}), 32'({TID_D, TID_D}));
    check("wr_wdata", m_wdata, 32'hCAFE_F00D);
    check("wr_wstrb_wlast", 32'({m_wstrb, m_wlast, m_wvalid}), 32'({4'hF, 1'b1, 1'b1}));
    check("wr_ready_copy", 32'({d_awready, d_wready}), 32'b11);
    tick();
    d_awvalid = 1'b0; d_wvalid = 1'b0; d_wlast = 1'b0;
    seen_b = 1'b0;
    for (int c = 0; c < 30 && !seen_b; c++) begin
      @(negedge aclk);
      check("raw_hold", 32'(m_arvalid), 32'd0);
      if (m_bvalid) begin
        seen_b = 1'b1;
        check("raw_d_bvalid", 32'({d_bvalid, d_bresp}), 32'({1'b1, 2'b00}));
      end
      @(posedge aclk); #1;
    end
    check("raw_b_seen", 32'(seen_b), 32'd1);
    @(negedge aclk);
    check("raw_gap", 32'(m_arvalid), 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("raw_issue", 32'(m_arvalid), 32'd1);
    check("raw_arid", 32'(m_arid), 32'(TID_D));
    check("raw_araddr", m_araddr, 32'h8000_1000);
    @(posedge aclk); #1;
    for (int c = 0; c < 30 && d_lasts < 1; c++) tick();
    check("raw_d_beats", 32'(d_beats), 32'd1);

    // Icache read proceeds while a write is outstanding.
    clear_counts();
    b_delay = 12;
    drive_write(32'h8000_2000, 32'h1234_5678);
    tick();
    d_awvalid = 1'b0; d_wvalid = 1'b0; d_wlast = 1'b0;
    i_araddr = 32'h1FC0_0400; i_arlen = 4'd1; i_exp = i_araddr; i_arvalid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge aclk);
      if (m_arvalid) begin
        found = 1'b1;
        check("iwr_arid", 32'(m_arid), 32'(TID_I));
        check("iwr_no_b_yet", 32'(m_bvalid), 32'd0);
      end
      @(posedge aclk); #1;
    end
    check("iwr_issued", 32'(found), 32'd1);
    for (int c = 0; c < 30 && i_lasts < 1; c++) tick();
    check("iwr_i_beats", 32'(i_beats), 32'd2);
    repeat (15) tick();

    // Reset in the middle of an icache burst.
    clear_counts();
    i_araddr = 32'h1FC0_0000; i_arlen = 4'h7; i_exp = i_araddr; i_arvalid = 1'b1;
    for (int c = 0; c < 60 && i_beats < 3; c++) tick();
    check("mid_beats", 32'(i_beats), 32'd3);
    aresetn = 1'b0;
    i_arvalid = 1'b0;
    @(negedge aclk);
    check("mid_rst_m_arvalid", 32'(m_arvalid), 32'd0);
    check("mid_rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    check("mid_rst_m_rready", 32'(m_rready), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 32'({m_arvalid, m_rready}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
